// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the EXE stage of the 32-bit ARM core:
//   - exe_cmd operation codes driven by the decode stage
//   - bit positions of N, Z, C, V inside the 4-bit status register
//   - packed bundle of the control bits passed through to the MEM stage
// -----------------------------------------------------------------------------
package arm_pkg;

   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   localparam int SR_N = 3;
   localparam int SR_Z = 2;
   localparam int SR_C = 1;
   localparam int SR_V = 0;

   // Flags written by logic/move ops (N,Z) and by arithmetic ops (all four).
   localparam logic [3:0] FLAG_MASK_NZ   = 4'b1100;
   localparam logic [3:0] FLAG_MASK_NZCV = 4'b1111;

   typedef struct packed {
      logic wb_en;
      logic mem_r_en;
      logic mem_w_en;
   } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU for the EXE stage.
// Ports:
//   val1, val2  : operands (Rn and shifted/immediate operand 2)
//   exe_cmd     : operation code (see arm_pkg)
//   c_in        : current carry flag, used by ADC/SBC
//   res         : result (0 for unknown codes)
//   nzcv_next   : flags the operation would produce
//   flag_mask   : which nzcv_next bits the operation is allowed to write
// -----------------------------------------------------------------------------
module alu_core
   import arm_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] val1,
   input  logic [DW-1:0] val2,
   input  logic [3:0]    exe_cmd,
   input  logic          c_in,
   output logic [DW-1:0] res,
   output logic [3:0]    nzcv_next,
   output logic [3:0]    flag_mask
);

   logic [DW-1:0] op_b_s;
   logic          cin_s;
   logic [DW:0]   sum_s;
   logic          v_s;

   // Subtraction is done as val1 + ~val2 + cin, so carry-out is the no-borrow flag.
   always_comb begin
      op_b_s = val2;
      cin_s  = 1'b0;
      case (exe_cmd)
         EXE_ADD: begin op_b_s = val2;  cin_s = 1'b0; end
         EXE_ADC: begin op_b_s = val2;  cin_s = c_in; end
         EXE_SUB: begin op_b_s = ~val2; cin_s = 1'b1; end
         EXE_SBC: begin op_b_s = ~val2; cin_s = c_in; end
         default: begin op_b_s = val2;  cin_s = 1'b0; end
      endcase
   end

   assign sum_s = {1'b0, val1} + {1'b0, op_b_s} + {{DW{1'b0}}, cin_s};

   // Signed overflow: both addends share a sign that differs from the result.
   assign v_s = (val1[DW-1] == op_b_s[DW-1]) && (sum_s[DW-1] != val1[DW-1]);

   // Result selection and which flags the operation owns.
   always_comb begin
      res       = {DW{1'b0}};
      flag_mask = 4'b0000;
      case (exe_cmd)
         EXE_MOV: begin res = val2;           flag_mask = FLAG_MASK_NZ;   end
         EXE_MVN: begin res = ~val2;          flag_mask = FLAG_MASK_NZ;   end
         EXE_ADD,
         EXE_ADC,
         EXE_SUB,
         EXE_SBC: begin res = sum_s[DW-1:0];  flag_mask = FLAG_MASK_NZCV; end
         EXE_AND: begin res = val1 & val2;    flag_mask = FLAG_MASK_NZ;   end
         EXE_ORR: begin res = val1 | val2;    flag_mask = FLAG_MASK_NZ;   end
         EXE_EOR: begin res = val1 ^ val2;    flag_mask = FLAG_MASK_NZ;   end
         default: begin res = {DW{1'b0}};     flag_mask = 4'b0000;        end
      endcase
   end

   assign nzcv_next = {res[DW-1], (res == {DW{1'b0}}), sum_s[DW], v_s};

endmodule

// File: rtl/exe_alu_stage.sv
// -----------------------------------------------------------------------------
// exe_alu_stage
// EXE-stage ALU plus EXE/MEM output register, owner of the NZCV register.
// Ports:
//   clk, rst (sync, active high), flush (drop held and incoming instruction)
//   in_valid/in_ready   : upstream handshake
//   exe_cmd, s_bit, val1, val2, st_val, dest, wb_en, mem_r_en, mem_w_en : instruction
//   out_valid/out_ready : MEM-stage handshake
//   alu_res, out_st_val, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en : registered
//   status              : NZCV register (N=bit3 .. V=bit0)
// Build option: EXE_SKID_EN adds a one-entry skid buffer so in_ready is registered.
// -----------------------------------------------------------------------------
module exe_alu_stage
   import arm_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    exe_cmd,
   input  logic          s_bit,
   input  logic [DW-1:0] val1,
   input  logic [DW-1:0] val2,
   input  logic [DW-1:0] st_val,
   input  logic [RW-1:0] dest,
   input  logic          wb_en,
   input  logic          mem_r_en,
   input  logic          mem_w_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] alu_res,
   output logic [DW-1:0] out_st_val,
   output logic [RW-1:0] out_dest,
   output logic          out_wb_en,
   output logic          out_mem_r_en,
   output logic          out_mem_w_en,
   output logic [3:0]    status
);

   logic [DW-1:0] res_s;
   logic [3:0]    nzcv_s;
   logic [3:0]    flag_mask_s;
   logic [3:0]    status_next_s;
   logic          accept_s;
   ctrl_t         ctrl_in_s;

   logic          out_valid_r;
   logic [DW-1:0] alu_res_r;
   logic [DW-1:0] st_val_r;
   logic [RW-1:0] dest_r;
   ctrl_t         ctrl_r;
   logic [3:0]    status_r;

   alu_core #(.DW(DW)) u_alu_core (
      .val1      (val1),
      .val2      (val2),
      .exe_cmd   (exe_cmd),
      .c_in      (status_r[SR_C]),
      .res       (res_s),
      .nzcv_next (nzcv_s),
      .flag_mask (flag_mask_s)
   );

   assign ctrl_in_s = {wb_en, mem_r_en, mem_w_en};
   assign accept_s  = in_valid && in_ready && !flush;

   // Flags are committed at accept time so the next accepted instruction sees them.
   always_comb begin
      status_next_s = status_r;
      if (accept_s && s_bit) begin
         status_next_s = (nzcv_s & flag_mask_s) | (status_r & ~flag_mask_s);
      end else begin
         status_next_s = status_r;
      end
   end

`ifdef EXE_SKID_EN
   logic          skid_valid_r;
   logic [DW-1:0] skid_res_r;
   logic [DW-1:0] skid_st_val_r;
   logic [RW-1:0] skid_dest_r;
   ctrl_t         skid_ctrl_r;

   // Registered ready: an accept is always possible while the skid entry is free.
   assign in_ready = !skid_valid_r;

   // Output register and skid buffer; the skid entry is only filled behind a stalled output.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r   <= 1'b0;
         alu_res_r     <= {DW{1'b0}};
         st_val_r      <= {DW{1'b0}};
         dest_r        <= {RW{1'b0}};
         ctrl_r        <= 3'b000;
         skid_valid_r  <= 1'b0;
         skid_res_r    <= {DW{1'b0}};
         skid_st_val_r <= {DW{1'b0}};
         skid_dest_r   <= {RW{1'b0}};
         skid_ctrl_r   <= 3'b000;
         status_r      <= 4'b0000;
      end else begin
         status_r <= status_next_s;
         if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
         end else if (!out_valid_r || out_ready) begin
            if (skid_valid_r) begin
               out_valid_r  <= 1'b1;
               alu_res_r    <= skid_res_r;
               st_val_r     <= skid_st_val_r;
               dest_r       <= skid_dest_r;
               ctrl_r       <= skid_ctrl_r;
               skid_valid_r <= 1'b0;
            end else if (accept_s) begin
               out_valid_r <= 1'b1;
               alu_res_r   <= res_s;
               st_val_r    <= st_val;
               dest_r      <= dest;
               ctrl_r      <= ctrl_in_s;
            end else begin
               out_valid_r <= 1'b0;
            end
         end else if (accept_s) begin
            skid_valid_r  <= 1'b1;
            skid_res_r    <= res_s;
            skid_st_val_r <= st_val;
            skid_dest_r   <= dest;
            skid_ctrl_r   <= ctrl_in_s;
         end else begin
            skid_valid_r <= skid_valid_r;
         end
      end
   end
`else
   assign in_ready = !out_valid_r || out_ready;

   // Single output register; a drain and a new accept in the same cycle simply overwrite it.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         alu_res_r   <= {DW{1'b0}};
         st_val_r    <= {DW{1'b0}};
         dest_r      <= {RW{1'b0}};
         ctrl_r      <= 3'b000;
         status_r    <= 4'b0000;
      end else begin
         status_r <= status_next_s;
         if (flush) begin
            out_valid_r <= 1'b0;
         end else if (accept_s) begin
            out_valid_r <= 1'b1;
            alu_res_r   <= res_s;
            st_val_r    <= st_val;
            dest_r      <= dest;
            ctrl_r      <= ctrl_in_s;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end
`endif

   assign out_valid    = out_valid_r;
   assign alu_res      = alu_res_r;
   assign out_st_val   = st_val_r;
   assign out_dest     = dest_r;
   assign out_wb_en    = ctrl_r.wb_en;
   assign out_mem_r_en = ctrl_r.mem_r_en;
   assign out_mem_w_en = ctrl_r.mem_w_en;
   assign status       = status_r;

endmodule

// File: tb/tb_exe_alu_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_alu_stage
// Self-checking bench for exe_alu_stage: directed vector table, hand-written
// stall/flush/reset/skid sequences and a randomized run, all checked against a
// queue-based reference model with an arithmetic ALU model.
// -----------------------------------------------------------------------------
module tb_exe_alu_stage;
   import arm_pkg::*;

   localparam int DW = 32;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, s_bit;
   logic [3:0]    exe_cmd;
   logic [DW-1:0] val1, val2, st_val;
   logic [RW-1:0] dest;
   logic          wb_en, mem_r_en, mem_w_en;
   logic          out_valid, out_ready;
   logic [DW-1:0] alu_res, out_st_val;
   logic [RW-1:0] out_dest;
   logic          out_wb_en, out_mem_r_en, out_mem_w_en;
   logic [3:0]    status;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   exe_alu_stage #(.DW(DW), .RW(RW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .exe_cmd(exe_cmd), .s_bit(s_bit), .val1(val1), .val2(val2), .st_val(st_val),
      .dest(dest), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
      .out_st_val(out_st_val), .out_dest(out_dest), .out_wb_en(out_wb_en),
      .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en), .status(status)
   );

   // Reference model: in-flight results in delivery order, plus the flag register.
   typedef struct {
      logic [31:0] res;
      logic [31:0] st_val;
      logic [3:0]  dest;
      logic [2:0]  ctrl;
   } item_t;
   item_t      q[$];
   logic [3:0] m_status;

   typedef struct {
      logic [3:0]  cmd;
      logic        s;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] res;
      logic [3:0]  st;
   } vec_t;
   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ALU model from plain integer arithmetic.
   function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] st_in, output logic [31:0] r, output logic [3:0] st_out);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint cin = st_in[1] ? 64'sd1 : 64'sd0;
      longint full = 0, sfull = 0;
      logic c = st_in[1], v = st_in[0], arith = 1'b0, known = 1'b1;
      r = 32'h0;
      case (cmd)
         4'd1: r = b;
         4'd9: r = ~b;
         4'd2: begin full = ua + ub;       sfull = sa + sb;       arith = 1'b1; c = (full >= 64'sh1_0000_0000); end
         4'd3: begin full = ua + ub + cin; sfull = sa + sb + cin; arith = 1'b1; c = (full >= 64'sh1_0000_0000); end
         4'd4: begin full = ua - ub;       sfull = sa - sb;       arith = 1'b1; c = (ua >= ub); end
         4'd5: begin full = ua - ub - (1 - cin); sfull = sa - sb - (1 - cin); arith = 1'b1; c = (ua >= ub + (1 - cin)); end
         4'd6: r = a & b;
         4'd7: r = a | b;
         4'd8: r = a ^ b;
         default: known = 1'b0;
      endcase
      if (arith) begin
         r = full[31:0];
         v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
      end
      st_out = known ? {r[31], (r == 32'h0), c, v} : st_in;
   endfunction

   task automatic drive(input logic iv, input logic [3:0] cmd, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic ordy);
      in_valid = iv; exe_cmd = cmd; s_bit = s; val1 = a; val2 = b; flush = fl; out_ready = ordy;
      st_val = $urandom; dest = 4'($urandom); wb_en = 1'($urandom);
      mem_r_en = 1'($urandom); mem_w_en = 1'($urandom);
   endtask

   // One clock: check in_ready, advance the model at the edge, then check outputs.
   task automatic tick();
      logic m_ready, acc, was_rst;
      logic [31:0] r;
      logic [3:0] st;
      item_t it;
`ifdef EXE_SKID_EN
      m_ready = (q.size() < 2);
`else
      m_ready = (q.size() == 0) || out_ready;
`endif
      #1;
      was_rst = rst;
      if (!was_rst) chk("in_ready", 32'(in_ready), 32'(m_ready));
      acc = in_valid && m_ready && !flush;
      ref_alu(exe_cmd, val1, val2, m_status, r, st);
      it.res = r; it.st_val = st_val; it.dest = dest; it.ctrl = {wb_en, mem_r_en, mem_w_en};
      @(posedge clk);
      if (was_rst) begin
         q.delete();
         m_status = 4'b0000;
      end else if (flush) begin
         q.delete();
      end else begin
         if (q.size() > 0 && out_ready) void'(q.pop_front());
         if (acc) begin
            q.push_back(it);
            if (s_bit) m_status = st;
         end
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("status", 32'(status), 32'(m_status));
      if (q.size() > 0) begin
         chk("alu_res", alu_res, q[0].res);
         chk("out_st_val", out_st_val, q[0].st_val);
         chk("out_dest", 32'(out_dest), 32'(q[0].dest));
         chk("out_ctrl", 32'({out_wb_en, out_mem_r_en, out_mem_w_en}), 32'(q[0].ctrl));
      end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pick[4];
      logic [3:0]  st_before;
      tbl[0]  = '{4'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110};
      tbl[1]  = '{4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001};
      tbl[2]  = '{4'd3, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 4'b1001};
      tbl[3]  = '{4'd4, 1'b1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1000};
      tbl[4]  = '{4'd5, 1'b1, 32'h0000_000A, 32'h0000_0002, 32'h0000_0007, 4'b0010};
      tbl[5]  = '{4'd3, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0009, 4'b0000};
      tbl[6]  = '{4'd1, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      tbl[7]  = '{4'd9, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
      tbl[8]  = '{4'd4, 1'b1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 4'b0010};
      tbl[9]  = '{4'd6, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, 4'b0110};
      tbl[10] = '{4'd7, 1'b1, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 4'b0010};
      tbl[11] = '{4'd8, 1'b1, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 4'b0010};
      tbl[12] = '{4'd0, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 4'b0010};
      tbl[13] = '{4'd15, 1'b1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 4'b0010};
      tbl[14] = '{4'd4, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
      tbl[15] = '{4'd9, 1'b0, 32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_0000, 4'b0011};
      pick[0] = 32'h0000_0000; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h7FFF_FFFF; pick[3] = 32'h8000_0000;
      m_status = 4'b0000;

      // Reset state
      rst = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_alu_res", alu_res, 32'h0);
      chk("rst_status", 32'(status), 32'h0);
      chk("rst_out_dest", 32'(out_dest), 32'h0);
      rst = 1'b0;

      // Directed vectors, one instruction at a time with the MEM stage always ready
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, tbl[i].cmd, tbl[i].s, tbl[i].v1, tbl[i].v2, 1'b0, 1'b1);
         tick();
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'h1);
         chk($sformatf("tbl%0d_res", i), alu_res, tbl[i].res);
         chk($sformatf("tbl%0d_status", i), 32'(status), 32'(tbl[i].st));
      end
      drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      chk("drain_valid", 32'(out_valid), 32'h0);

`ifndef EXE_SKID_EN
      // Stall for three cycles with a waiting instruction, then release
      drive(1'b1, EXE_ADD, 1'b0, 32'h1, 32'h2, 1'b0, 1'b1);
      tick();
      drive(1'b1, EXE_EOR, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         chk("stall_res", alu_res, 32'h0000_0003);
      end
      out_ready = 1'b1;
      tick();
      chk("release_res", alu_res, 32'h5555_5555);
      in_valid = 1'b0;
      tick();
      chk("release_drained", 32'(out_valid), 32'h0);
`else
      // Two back-to-back instructions into a stalled output: second waits in the skid entry
      drive(1'b1, EXE_ADD, 1'b0, 32'h1, 32'h2, 1'b0, 1'b0);
      tick();
      drive(1'b1, EXE_ORR, 1'b0, 32'h0000_0F00, 32'h0000_00F0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("skid_in_ready", 32'(in_ready), 32'h0);
      chk("skid_first", alu_res, 32'h0000_0003);
      out_ready = 1'b1;
      tick();
      chk("skid_second", alu_res, 32'h0000_0FF0);
      tick();
      chk("skid_drained", 32'(out_valid), 32'h0);
`endif

      // Flush against a held result and a flag-setting incoming instruction
      drive(1'b1, EXE_MOV, 1'b1, 32'h0, 32'h0000_0042, 1'b0, 1'b0);
      tick();
      st_before = m_status;
      drive(1'b1, EXE_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1);
      tick();
      chk("flush_valid", 32'(out_valid), 32'h0);
      chk("flush_status", 32'(status), 32'(st_before));

      // Reset in the middle of a stalled transfer
      drive(1'b1, EXE_SUB, 1'b1, 32'h3, 32'h5, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b1, EXE_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      tick();
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_status", 32'(status), 32'h0);
      chk("midrst_res", alu_res, 32'h0);
      rst = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
               ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : 32'($urandom),
               ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 3)] : 32'($urandom),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
         tick();
      end
      drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
